// File: rtl/logo_pos_ctrl.sv
// logo_pos_ctrl: bouncing/wrapping logo position animator that writes start_x/start_y into the logo mixer
// Optional feature: define LOGO_POS_CTRL_WRAP_EN to make CTRL[2] select wrap mode instead of bounce.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   s_address/s_wrdata/s_wr    host register writes (0 CTRL, 1 STEP, 2 POS, 3 STATUS)
//   s_rd/s_rddata              host register reads, combinational
//   frame_eop                  last pixel of an input frame
//   control_in_*               video control packets (width/height snoop)
//   control_logo_*             logo control packets (width/height snoop)
//   m_address/m_wrdata/m_wr    two-beat register-write master towards the mixer
//   busy                       update sequence in progress
module logo_pos_ctrl #(
    parameter logic [15:0] INIT_X    = 16'd10,
    parameter logic [15:0] INIT_Y    = 16'd100,
    parameter logic [7:0]  FRAME_DIV = 8'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  s_address,
    input  logic [31:0] s_wrdata,
    input  logic        s_wr,
    input  logic        s_rd,
    output logic [31:0] s_rddata,
    input  logic        frame_eop,
    input  logic [35:0] control_in_data,
    input  logic        control_in_valid,
    input  logic [35:0] control_logo_data,
    input  logic        control_logo_valid,
    output logic [1:0]  m_address,
    output logic [31:0] m_wrdata,
    output logic        m_wr,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CALC, WR_X, WR_Y} state_t;
    state_t state, state_nx;
    logic enable, pause, wrap;
    logic [7:0] dx, dy, div_cnt;
    logic [15:0] x, y, lat_y, frame_cnt, vid_w, vid_h, logo_w, logo_h, max_x, max_y;
    logic dir_x, dir_y, force_pos, pos_fresh, pos_pend, do_step;
    logic [31:0] pend_data, pos_data;
    logic [16:0] nx, ny;
    logic div_last, step_go, trig, pos_wr, pos_apply;
    logic unused;

    // Returns {dir, pos}; dir 0 is forward. mv=0 means clamp only.
    function automatic logic [16:0] step_axis(input logic [15:0] p, input logic [7:0] d,
                                              input logic [15:0] mx, input logic dir,
                                              input logic wr, input logic mv);
        logic [16:0] c, s;
        c = {1'b0, (p > mx) ? mx : p};
        s = c + {9'd0, d};
        if (!mv || d == 8'd0)
            step_axis = {dir & ~wr, c[15:0]};
        else if (wr)
            step_axis = {1'b0, (s > {1'b0, mx}) ? 16'd0 : s[15:0]};
        else if (!dir)
            step_axis = (s >= {1'b0, mx}) ? {1'b1, mx} : {1'b0, s[15:0]};
        else
            step_axis = (c <= {9'd0, d}) ? 17'd0 : {1'b1, c[15:0] - {8'd0, d}};
    endfunction

    assign unused    = ^{control_in_data[3:0], control_logo_data[3:0]};
    assign max_x     = (logo_w >= vid_w) ? 16'd0 : vid_w - logo_w;
    assign max_y     = (logo_h >= vid_h) ? 16'd0 : vid_h - logo_h;
    assign div_last  = div_cnt == FRAME_DIV - 8'd1;
    assign step_go   = frame_eop & enable & ~pause & div_last;
    assign trig      = step_go | (frame_eop & force_pos);
    assign pos_wr    = s_wr & (s_address == 2'd2);
    // A POS write landing in CALC is held for one cycle so it cannot race the step result.
    assign pos_apply = (state != CALC) & (pos_wr | pos_pend);
    assign pos_data  = pos_wr ? s_wrdata : pend_data;
    assign nx        = step_axis(x, dx, max_x, dir_x, wrap, do_step);
    assign ny        = step_axis(y, dy, max_y, dir_y, wrap, do_step);
    assign busy      = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (trig ? CALC : IDLE) :
                   state == CALC ? WR_X :
                   state == WR_X ? WR_Y : IDLE;
    end

    always_comb begin
        m_wr      = (state == WR_X) || (state == WR_Y);
        m_address = (state == WR_Y) ? 2'd1 : 2'd0;
        m_wrdata  = (state == WR_X) ? {16'd0, x} : (state == WR_Y) ? {16'd0, lat_y} : 32'd0;
    end

    always_comb begin
        s_rddata = !s_rd            ? 32'd0 :
                   s_address == 2'd0 ? {29'd0, wrap, pause, enable} :
                   s_address == 2'd1 ? {16'd0, dy, dx} :
                   s_address == 2'd2 ? {y, x} :
                                       {13'd0, busy, dir_y, dir_x, frame_cnt};
    end

`ifndef LOGO_POS_CTRL_WRAP_EN
    assign wrap = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable    <= 1'b0;
            pause     <= 1'b0;
`ifdef LOGO_POS_CTRL_WRAP_EN
            wrap      <= 1'b0;
`endif
            dx        <= 8'd1;
            dy        <= 8'd1;
            x         <= INIT_X;
            y         <= INIT_Y;
            lat_y     <= 16'd0;
            dir_x     <= 1'b0;
            dir_y     <= 1'b0;
            frame_cnt <= 16'd0;
            div_cnt   <= 8'd0;
            vid_w     <= 16'd1920;
            vid_h     <= 16'd1080;
            logo_w    <= 16'd0;
            logo_h    <= 16'd0;
            force_pos <= 1'b0;
            pos_fresh <= 1'b0;
            pos_pend  <= 1'b0;
            pend_data <= 32'd0;
            do_step   <= 1'b0;
        end else begin
            if (frame_eop) begin
                frame_cnt <= frame_cnt + 16'd1;
                div_cnt   <= div_last ? 8'd0 : div_cnt + 8'd1;
            end
            if (control_in_valid) begin
                vid_w <= control_in_data[35:20];
                vid_h <= control_in_data[19:4];
            end
            if (control_logo_valid) begin
                logo_w <= control_logo_data[35:20];
                logo_h <= control_logo_data[19:4];
            end
            if (s_wr && s_address == 2'd0) begin
                enable <= s_wrdata[0];
                pause  <= s_wrdata[1];
`ifdef LOGO_POS_CTRL_WRAP_EN
                wrap   <= s_wrdata[2];
`endif
            end
            if (s_wr && s_address == 2'd1) begin
                dx <= s_wrdata[7:0];
                dy <= s_wrdata[15:8];
            end
            if (state == IDLE && trig) do_step <= step_go;
            if (state == CALC && pos_wr) begin
                pos_pend  <= 1'b1;
                pend_data <= s_wrdata;
            end else if (pos_apply) begin
                pos_pend <= 1'b0;
            end
            // pos_fresh keeps a POS write that arrived after CALC from being cleared by WR_Y.
            if (state == CALC) begin
                x         <= nx[15:0];
                dir_x     <= nx[16];
                y         <= ny[15:0];
                dir_y     <= ny[16];
                lat_y     <= ny[15:0];
                pos_fresh <= 1'b0;
            end else if (pos_apply) begin
                x         <= pos_data[15:0];
                y         <= pos_data[31:16];
                force_pos <= 1'b1;
                pos_fresh <= 1'b1;
            end else if (state == WR_Y && !pos_fresh) begin
                force_pos <= 1'b0;
            end
        end
    end
endmodule

// File: doc/logo_pos_ctrl.md
# logo_pos_ctrl

Animation controller for the logo mixer. Once per N frames it computes a new logo position that moves across the active picture and bounces off the edges. It then writes the new start_x/start_y into the mixer's slave registers through a two-beat register-write master. It snoops the same control packets the mixer consumes, so its bounds track the live video and logo dimensions. A host slave port gives access to enable, step size, forced position and status.

## Interface
- INIT_X, 10: reset X position; must match the mixer's reset start_x.
- INIT_Y, 100: reset Y position; must match the mixer's reset start_y.
- FRAME_DIV, 1: frames per position update, range 1..255.

Clock and reset: reset rst, asynchronous, active-high; clock clk.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_address  in  2  host register select: 0 CTRL, 1 STEP, 2 POS, 3 STATUS
- s_wrdata  in  32  host write data
- s_wr  in  1  host write strobe, single cycle
- s_rd  in  1  host read strobe
- s_rddata  out  32  read data, combinational from s_address
- frame_eop  in  1  one-cycle pulse on the accepted last pixel of an input frame
- control_in_data  in  36  video control packet: [35:20] width, [19:4] height
- control_in_valid  in  1  video control packet valid
- control_logo_data  in  36  logo control packet, same field layout
- control_logo_valid  in  1  logo control packet valid
- m_address  out  2  mixer register address
- m_wrdata  out  32  mixer write data; [15:0] position, [31:16] zero
- m_wr  out  1  mixer write strobe
- busy  out  1  high while in CALC, WR_X or WR_Y

## Operation
- Registers:
  - CTRL: [0] enable, [1] pause, [2] wrap.
  - STEP: [7:0] dx, [15:8] dy.
  - POS: [15:0] x, [31:16] y. A write loads x/y and sets `force`.
  - STATUS: [15:0] frame count, [16] dir_x, [17] dir_y, [18] busy.
- Reset values:
  - enable=0; dx=dy=1; x=INIT_X, y=INIT_Y; dir_x=dir_y=+; frame count 0.
  - Video dims 1920x1080; logo dims 0x0.
  - All outputs 0.
- Dimension registers load on control_in_valid / control_logo_valid, exactly as the mixer does.
- Bounds are 16-bit unsigned: max_x = (logo_w >= vid_w) ? 0 : vid_w - logo_w. max_y is defined the same way.
- The frame counter increments on every frame_eop and wraps at 16 bits. A divider counts 0..FRAME_DIV-1.
- FSM states are IDLE, CALC, WR_X, WR_Y.
  - IDLE→CALC: on frame_eop when either (enable & !pause & divider==FRAME_DIV-1) or force.
  - CALC: compute the new x/y, then go to WR_X. When the transition was caused by force alone, skip the step and only clamp.
  - WR_X: m_wr=1, m_address=0, m_wrdata=x. Go to WR_Y.
  - WR_Y: m_wr=1, m_address=1, m_wrdata=y. Clear force, go to IDLE.
- Step rule for X (Y is identical, using dy and dir_y), computed in 17 bits:
  - Forward: if x+dx >= max_x, then x=max_x and dir=−; else x+=dx.
  - Backward: if x <= dx, then x=0 and dir=+; else x−=dx.
  - dx=0 holds the position.
  - If x > max_x on entry to CALC, clamp x to max_x first, then step.
- Simultaneous events:
  - A frame_eop in CALC/WR_X/WR_Y still counts in the frame counter but does not retrigger the FSM.
  - A host write to STEP or CTRL during busy takes effect at the next CALC.
  - A host write to POS during busy is deferred one cycle if it collides with CALC. The FSM never loses it.
- Clearing enable mid-sequence finishes the current WR_X/WR_Y pair.
- Reset mid-sequence aborts immediately: m_wr=0 and FSM=IDLE.

## Timing
- The cycle of frame_eop is T0. CALC runs at T0+1, WR_X at T0+2, WR_Y at T0+3, and the FSM is back in IDLE at T0+4.
- The mixer latches its start registers at its next video_in_eop. A new position is therefore on screen two frames after the triggering eop.
- m_wr is high for exactly two consecutive cycles per update and never otherwise.
- s_rddata is combinational and valid in the same cycle as s_rd.

## Configuration
- Macro: LOGO_POS_CTRL_WRAP_EN.
- Defined: CTRL[2]=1 selects wrap mode.
  - Forward overshoot (x+dx > max_x) sets x=0 and keeps dir=+.
  - Backward steps are unused; dir is forced to + when wrap is set.
- Undefined: CTRL[2] is not writable and reads 0; only bounce mode exists.

## Test plan
- Bounce X: vid 100x50, logo 20x10 (max_x=80), dx=30, x=10, enable, FRAME_DIV=1. Successive writes to address 0 must be 40, 70, 80 (dir flips), 50, 20, 0 (dir flips), 30.
- Write cadence: FRAME_DIV=3, 9 eops. Expect exactly 3 update sequences, each with two m_wr cycles at eop+2 and eop+3, at addresses 0 then 1.
- Oversized logo: logo 200x100 on video 100x50. Every update must write x=0, y=0.
- Force: enable=0, host writes POS=0x0020_0005. At the next eop, expect writes 5 then 32; no update at the following eop.
- Wrap (macro defined): max_x=80, dx=30, x=70, wrap=1. Expect next write 0, then 30.
- Reset mid-sequence: assert rst in WR_X. m_wr must drop the same cycle, STATUS must read 0 with x=INIT_X, and busy must be 0.
